binary_frame_ctrl: RTL and testbench

- Sequences sign-binarization of one layer's accumulator outputs, in frames, for the BNN VAD datapath.
- Accepts WIDTH signed accumulator lanes per beat over a valid/ready stream and converts each lane to one sign bit.
- Packs N_BEATS beats into one frame word and hands that word to the next binary layer over a second valid/ready stream.
- A 3-state FSM with a beat counter and length checking governs the frame.

---
 rtl/binary_frame_ctrl.sv | 96 +++++++++
 tb/tb_binary_frame_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/binary_frame_ctrl.sv
// binary_frame_ctrl: packs sign-binarized accumulator lanes into frame words for the next binary layer
// Ports: clk/rst_n (async active-low); start arms a frame from IDLE;
//   in_valid/in_ready/in_data/in_last: WIDTH signed DEPTH-bit lanes per beat;
//   out_valid/out_ready/out_bits: one FW = WIDTH*N_BEATS bit frame word (1 = +1, 0 = -1);
//   busy: frame in progress; err_len: sticky in_last/beat-count mismatch.
// Define BIN_THRESH_EN to add a signed thresh input latched at start; otherwise lanes compare against 0.
module binary_frame_ctrl #(
  parameter int DEPTH   = 32,
  parameter int WIDTH   = 3,
  parameter int N_BEATS = 8,
  parameter int CNT_W   = $clog2(N_BEATS) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*DEPTH-1:0]     in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*N_BEATS-1:0]   out_bits,
  output logic                       busy,
`ifdef BIN_THRESH_EN
  input  logic [DEPTH-1:0]           thresh,
`endif
  output logic                       err_len
);
  localparam int FW = WIDTH * N_BEATS;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  state_t             state, state_d;
  logic [CNT_W-1:0]   beat_cnt;
  logic [FW-1:0]      pack, pack_nxt;
  logic [WIDTH-1:0]   bin;
  logic [DEPTH-1:0]   thr;
  logic               fire, last_beat, arm;
  assign in_ready  = state == COLLECT;
  assign fire      = in_valid && in_ready;
  assign last_beat = beat_cnt == CNT_W'(N_BEATS - 1);
  assign arm       = state == IDLE && start;
`ifdef BIN_THRESH_EN
  logic [DEPTH-1:0] thr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) thr_q <= '0;
    else if (arm) thr_q <= thresh;
  assign thr = thr_q;
`else
  assign thr = '0;
`endif
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++)
      bin[i] = $signed(in_data[i*DEPTH +: DEPTH]) >= $signed(thr);
  end
  // Only the slice addressed by the beat counter is replaced; earlier beats are kept.
  always_comb begin
    pack_nxt = pack;
    for (int b = 0; b < N_BEATS; b++)
      if (beat_cnt == CNT_W'(b)) pack_nxt[b*WIDTH +: WIDTH] = bin;
  end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = start ? COLLECT : IDLE;
      COLLECT: state_d = (fire && last_beat) ? EMIT : COLLECT;
      EMIT:    state_d = out_ready ? IDLE : EMIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      err_len   <= 1'b0;
      beat_cnt  <= '0;
      pack      <= '0;
    end else begin
      state     <= state_d;
      busy      <= state_d != IDLE;
      out_valid <= state_d == EMIT;
      if (arm) begin
        beat_cnt <= '0;
        pack     <= '0;
        err_len  <= 1'b0;
      end
      if (fire) begin
        beat_cnt <= beat_cnt + 1'b1;
        pack     <= pack_nxt;
        if (in_last != last_beat) err_len <= 1'b1;
        if (last_beat) out_bits <= pack_nxt;
      end
    end
  end
endmodule

// File: tb/tb_binary_frame_ctrl.sv
// tb_binary_frame_ctrl: scoreboard bench for binary_frame_ctrl with directed frames
module tb_binary_frame_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [95:0] in_data = '0;
  logic        in_ready, out_valid, busy, err_len;
  logic [23:0] out_bits;
`ifdef BIN_THRESH_EN
  logic [31:0] thresh = '0;
`endif
  int total = 0, bad = 0;
  logic [24:0] sb[$];
  always #5 clk = ~clk;
  binary_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .busy(busy),
`ifdef BIN_THRESH_EN
    .thresh(thresh),
`endif
    .err_len(err_len)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_frame", 1, 0);
      else begin
        logic [24:0] e;
        e = sb.pop_front();
        chk("frame_bits", out_bits, e[23:0]);
        chk("frame_err", err_len, e[24]);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame(input logic [31:0] th);
`ifdef BIN_THRESH_EN
    thresh = th;
`else
    if (th != 0) $display("thresh ignored in this build");
`endif
    start = 1;
    tick();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_err_clear", err_len, 0);
  endtask
  function automatic logic [95:0] lanes(input int mode, input int b);
    logic [2:0] p;
    p = 3'(b);
    case (mode)
      0: return {32'sd0, -32'sd1, 32'sd5};
      1: return {32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
      2: return {p[2] ? 32'sd7 : -32'sd7, p[1] ? 32'sd7 : -32'sd7, p[0] ? 32'sd7 : -32'sd7};
      default: return {-32'sd20, 32'sd9, 32'sd10};
    endcase
  endfunction
  task automatic send_frame(input int mode, input int last_at, input bit gap, input int nb);
    logic err_exp = 0;
    for (int b = 0; b < nb; b++) begin
      int n = 0;
      in_data = lanes(mode, b);
      in_last = (b == last_at);
      in_valid = 1;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (n == 20) chk("in_ready_timeout", 0, 1);
`ifdef BIN_THRESH_EN
      if (b == 4) thresh = -32'sd100;
`endif
      tick();
      in_valid = 0;
      in_last = 0;
      err_exp = err_exp | ((b == 7) != (b == last_at));
      chk("err_len_beat", err_len, err_exp);
      if (gap && b < nb - 1) tick();
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    if (n == 50) chk("idle_timeout", 0, 1);
  endtask
  task automatic frame(input int mode, input int last_at, input logic [23:0] exp, input logic e);
    sb.push_back({e, exp});
    start_frame(0);
    send_frame(mode, last_at, 0, 8);
    chk("latency_out_valid", out_valid, 1);
    wait_idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_len, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    frame(0, 7, 24'hB6DB6D, 0);
    // backpressure: toggling in_valid, then 5 stalled EMIT cycles with an ignored start
    out_ready = 0;
    sb.push_back({1'b0, 24'hB6DB6D});
    start_frame(0);
    send_frame(0, 7, 1, 8);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_bits", out_bits, 24'hB6DB6D);
      start = (c == 2);
      tick();
    end
    start = 0;
    out_ready = 1;
    wait_idle();
    tick();
    chk("start_not_queued", busy, 0);
    frame(0, 3, 24'hB6DB6D, 1);
    frame(1, 7, 24'hDB6DB6, 0);
    frame(2, 7, 24'hFAC688, 0);
    // reset mid-frame after beat 4 with err_len already set
    start_frame(0);
    send_frame(0, 0, 0, 5);
    chk("pre_rst_err", err_len, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_bits", out_bits, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_len, 0);
    tick();
    rst_n = 1;
    tick();
    frame(2, 7, 24'hFAC688, 0);
`ifdef BIN_THRESH_EN
    sb.push_back({1'b0, 24'h249249});
    start_frame(32'sd10);
    send_frame(3, 7, 0, 8);
    wait_idle();
`else
    frame(3, 7, 24'h6DB6DB, 0);
`endif
    for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
